fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Control end of the EX-stage operand forwarding path. It produces the 2-bit select lines consumed by the 64-bit 3:1 operand muxes.
- Encoding: 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result.
- Internally shadows the pipeline destination-register state (EX, MEM, WB slots) from ID-stage decode info.
- Also generates the load-use stall and bubble controls for the 5-stage RISC-V pipeline.

Parameters:
- REG_AW, 5, register address width.
- STAT_W, 32, width of statistics counters (optional feature only).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all slot state.
- id_valid  input  1  ID-stage instruction is real (not a bubble).
- id_rs1  input  REG_AW  ID source register 1.
- id_rs2  input  REG_AW  ID source register 2.
- id_use_rs1  input  1  instruction reads rs1.
- id_use_rs2  input  1  instruction reads rs2.
- id_rd  input  REG_AW  ID destination register.
- id_reg_write  input  1  instruction writes rd.
- id_mem_read  input  1  instruction is a load.
- flush  input  1  branch/jump redirect; kills the ID and EX instructions.
- forward_a  output  2  select for EX operand A mux.
- forward_b  output  2  select for EX operand B mux.
- stall  output  1  hold PC and IF/ID this cycle.
- ex_bubble  output  1  load ID/EX with a NOP this cycle.

Behaviour:
- Slot state: EX, MEM and WB slots, each holding {valid, rs1, rs2, use_rs1, use_rs2, rd, reg_write, mem_read}. The EX slot also holds rs1/rs2.
- Reset (async): all slot valid bits = 0. Outputs: forward_a = forward_b = 00, stall = 0, ex_bubble = 0.
- Each rising edge (not in reset):
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields with valid = id_valid, except that EX becomes invalid when stall = 1 or flush = 1.
- stall (combinational):
  - Asserted when EX.valid & EX.mem_read & EX.rd != 0 and (id_use_rs1 & id_rs1 == EX.rd, or id_use_rs2 & id_rs2 == EX.rd), with id_valid = 1.
  - Forced to 0 when flush = 1; flush wins.
- ex_bubble = stall | flush.
- Stall duration: exactly 1 cycle per load-use pair. In the next cycle the load is in MEM and EX holds a bubble, so no re-stall.
- Forwarding (combinational, computed for the EX slot operand rs1; identical logic for rs2 to forward_b):
  - 10 if MEM.valid & MEM.reg_write & MEM.rd != 0 & MEM.rd == EX.rs1 & EX.use_rs1.
  - Else 01 if the same conditions hold for the WB slot.
  - Else 00.
- Priority: EX/MEM over MEM/WB, i.e. the youngest producer wins.
- x0 is never forwarded.
- 11 is never driven.
- Outputs are 00 whenever EX.valid = 0.
- Latency: a producer in the MEM slot is visible to the EX consumer in the same cycle. No added delay.
- Reset mid-operation: all in-flight state is dropped immediately. The first post-reset instruction sees forward = 00.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- With it defined, three additional outputs, each STAT_W wide:
  - stat_stall_cycles: increments on each cycle with stall = 1.
  - stat_fwd_exmem: increments once per cycle where either select = 10.
  - stat_fwd_memwb: increments once per cycle where either select = 01.
- Counters saturate at all-ones and clear on reset.
- Without it: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- ALU back-to-back: `add x5,x1,x2` then `sub x6,x5,x3` -> the cycle sub is in EX gives forward_a = 10, forward_b = 00, stall = 0.
- Distance-2 dependency: `add x5`, `nop`, `or x7,x3,x5` -> forward_b = 01 when or is in EX.
- Double producer: `addi x5` then `addi x5` then `add x8,x5,x5` -> forward_a = forward_b = 10 (the younger producer wins over 01).
- Load-use: `ld x9` then `add x10,x9,x1` -> stall = 1 and ex_bubble = 1 for exactly one cycle, then forward_a = 01 when add reaches EX. With FWD_HAZARD_STATS_EN, stat_stall_cycles = 1.
- x0 and flush:
  - `addi x0,x0,1` then `add x4,x0,x0` -> selects stay 00.
  - flush asserted in the same cycle as a load-use match -> stall = 0, ex_bubble = 1.
- Async reset mid-stream: assert reset between edges while forward_a = 10 -> outputs go to 00 immediately. After release, `add x2,x5,x5` sees 00.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand forwarding selects plus load-use stall/bubble control for a 5-stage pipeline.
// Latency: selects, stall and ex_bubble are combinational from the EX/MEM/WB slot shadows; slots advance every edge.
// Backpressure: stall holds PC and IF/ID for exactly one cycle per load-use pair; optional counters under FWD_HAZARD_STATS_EN.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5
`ifdef FWD_HAZARD_STATS_EN
  ,
  parameter int STAT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic              ex_bubble
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall_cycles,
  output logic [STAT_W-1:0] stat_fwd_exmem,
  output logic [STAT_W-1:0] stat_fwd_memwb
`endif
);

  // The EX slot is the consumer, so it keeps source operands; later slots only need producer info.
  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } ex_slot_t;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } prod_slot_t;

  ex_slot_t   ex_q, ex_d;
  prod_slot_t mem_q, mem_d;
  prod_slot_t wb_q, wb_d;
  logic       ld_use_hit;

  // Youngest producer wins: MEM (10) beats WB (01); x0 and bubbles never forward.
  function automatic logic [1:0] fwd_sel(input logic ex_vld, input logic use_rs,
                                         input logic [REG_AW-1:0] rs,
                                         input prod_slot_t mem, input prod_slot_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_vld && use_rs) begin
      if (mem.vld && mem.reg_write && (mem.rd != '0) && (mem.rd == rs)) begin
        sel = 2'b10;
      end else if (wb.vld && wb.reg_write && (wb.rd != '0) && (wb.rd == rs)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // Load-use detection against the load sitting in EX, and operand selects for the EX instruction.
  always_comb begin
    ld_use_hit = ex_q.vld & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                 ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));
    // A redirect kills the dependent ID instruction, so there is nothing to hold.
    stall      = ld_use_hit & ~flush;
    ex_bubble  = (stall | flush) & ~reset;
    forward_a  = fwd_sel(ex_q.vld, ex_q.use_rs1, ex_q.rs1, mem_q, wb_q);
    forward_b  = fwd_sel(ex_q.vld, ex_q.use_rs2, ex_q.rs2, mem_q, wb_q);
  end

  // Slot advance: ID enters EX unless it is stalled or flushed, in which case EX takes a bubble.
  always_comb begin
    ex_d = '{vld:       id_valid & ~stall & ~flush,
             rs1:       id_rs1,
             rs2:       id_rs2,
             use_rs1:   id_use_rs1,
             use_rs2:   id_use_rs2,
             rd:        id_rd,
             reg_write: id_reg_write,
             mem_read:  id_mem_read};
    mem_d = '{vld: ex_q.vld, rd: ex_q.rd, reg_write: ex_q.reg_write};
    wb_d  = mem_q;
  end

  // Slot registers; reset drops every in-flight instruction at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] exmem_cnt_q, exmem_cnt_d;
  logic [STAT_W-1:0] memwb_cnt_q, memwb_cnt_d;

  // Saturating event counters; either operand using a path counts once per cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    exmem_cnt_d = exmem_cnt_q;
    memwb_cnt_d = memwb_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
    if (((forward_a == 2'b10) || (forward_b == 2'b10)) && (exmem_cnt_q != '1)) begin
      exmem_cnt_d = exmem_cnt_q + STAT_W'(1);
    end
    if (((forward_a == 2'b01) || (forward_b == 2'b01)) && (memwb_cnt_q != '1)) begin
      memwb_cnt_d = memwb_cnt_q + STAT_W'(1);
    end
  end

  // Counter registers, cleared with the slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      exmem_cnt_q <= '0;
      memwb_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      exmem_cnt_q <= exmem_cnt_d;
      memwb_cnt_q <= memwb_cnt_d;
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
  assign stat_fwd_exmem    = exmem_cnt_q;
  assign stat_fwd_memwb    = memwb_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed program snippets plus random instruction streams.
// An instruction-level pipeline model predicts each cycle's outputs into a queue; a monitor pops and compares.
`timescale 1ns/1ps
module tb_fwd_hazard_ctrl;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic          id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
  logic [1:0]    forward_a, forward_b;
  logic          stall, ex_bubble;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0]   stat_stall_cycles, stat_fwd_exmem, stat_fwd_memwb;
`endif

  fwd_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall), .ex_bubble(ex_bubble)
`ifdef FWD_HAZARD_STATS_EN
    , .stat_stall_cycles(stat_stall_cycles), .stat_fwd_exmem(stat_fwd_exmem),
    .stat_fwd_memwb(stat_fwd_memwb)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; int rs1; bit u1; int rs2; bit u2; int rd; bit rw; bit mr;
  } instr_t;

  typedef struct {
    int fa; int fb; bit st; bit eb;
    longint s_stall; longint s_ex; longint s_wb; int tag;
  } exp_t;

  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  exp_t   exp_q[$];
  int     checks = 0;
  int     passes = 0;
  int     cyc = 0;
  bit     last_stall = 0;

  // Model: the instruction in EX and the two older instructions (index 0 = one stage past EX).
  instr_t ex_m;
  instr_t older[$];
  longint cnt_stall = 0, cnt_ex = 0, cnt_wb = 0;

  function automatic instr_t mk(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit rw, bit mr);
    instr_t i;
    i.v = v; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2; i.rd = rd; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic instr_t bubble();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic model_clear();
    ex_m = bubble();
    older.delete();
    older.push_back(bubble());
    older.push_back(bubble());
    cnt_stall = 0; cnt_ex = 0; cnt_wb = 0;
  endtask

  // Nearest older instruction that writes a nonzero rs supplies the operand: 2 one stage away, 1 two stages away.
  function automatic int model_sel(int rs, bit u);
    if (!ex_m.v || !u) return 0;
    foreach (older[k]) begin
      if (older[k].v && older[k].rw && older[k].rd != 0 && older[k].rd == rs) return (k == 0) ? 2 : 1;
    end
    return 0;
  endfunction

  function automatic bit model_stall(instr_t i, bit fl);
    if (fl || !i.v || !ex_m.v || !ex_m.mr || ex_m.rd == 0) return 0;
    return (i.u1 && i.rs1 == ex_m.rd) || (i.u2 && i.rs2 == ex_m.rd);
  endfunction

  task automatic drive_and_expect(input instr_t i, input bit fl, output exp_t e);
    id_valid = i.v; id_rs1 = AW'(i.rs1); id_rs2 = AW'(i.rs2); id_rd = AW'(i.rd);
    id_use_rs1 = i.u1; id_use_rs2 = i.u2; id_reg_write = i.rw; id_mem_read = i.mr;
    flush = fl;
    e.tag = cyc;
    if (reset) begin
      e.fa = 0; e.fb = 0; e.st = 0; e.eb = 0; e.s_stall = 0; e.s_ex = 0; e.s_wb = 0;
    end else begin
      e.fa = model_sel(ex_m.rs1, ex_m.u1);
      e.fb = model_sel(ex_m.rs2, ex_m.u2);
      e.st = model_stall(i, fl);
      e.eb = e.st || fl;
      e.s_stall = cnt_stall; e.s_ex = cnt_ex; e.s_wb = cnt_wb;
    end
    last_stall = e.st;
    exp_q.push_back(e);
  endtask

  task automatic commit(input instr_t i, input bit fl, input exp_t e);
    cyc++;
    if (reset) begin
      model_clear();
    end else begin
      if (e.st && cnt_stall < CNT_MAX) cnt_stall++;
      if ((e.fa == 2 || e.fb == 2) && cnt_ex < CNT_MAX) cnt_ex++;
      if ((e.fa == 1 || e.fb == 1) && cnt_wb < CNT_MAX) cnt_wb++;
      void'(older.pop_back());
      older.push_front(ex_m);
      if (i.v && !e.st && !fl) ex_m = i;
      else ex_m = bubble();
    end
  endtask

  // One pipeline cycle: starts and ends just after a rising edge.
  task automatic issue(input instr_t i, input bit fl);
    exp_t e;
    drive_and_expect(i, fl, e);
    @(posedge clk); #1;
    commit(i, fl, e);
  endtask

  // Presents an instruction and holds it in ID for as long as it is stalled.
  task automatic send(input instr_t i);
    int n;
    n = 0;
    issue(i, 0);
    while (last_stall && n < 4) begin
      issue(i, 0);
      n++;
    end
  endtask

  function automatic instr_t alu(int rd, int rs1, int rs2);
    return mk(1, rs1, 1, rs2, 1, rd, 1, 0);
  endfunction
  function automatic instr_t addi(int rd, int rs1);
    return mk(1, rs1, 1, 0, 0, rd, 1, 0);
  endfunction
  function automatic instr_t ld(int rd, int rs1);
    return mk(1, rs1, 1, 0, 0, rd, 1, 1);
  endfunction
  function automatic instr_t nop();
    return addi(0, 0);
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.v  = ($urandom_range(0, 7) != 0);
    i.rs1 = $urandom_range(0, 7); i.rs2 = $urandom_range(0, 7); i.rd = $urandom_range(0, 7);
    i.u1 = $urandom_range(0, 1); i.u2 = $urandom_range(0, 1);
    i.rw = ($urandom_range(0, 3) != 0);
    i.mr = i.rw && ($urandom_range(0, 2) == 0);
    return i;
  endfunction

  // Monitor: compares DUT outputs against the oldest prediction shortly after each falling edge or reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (forward_a === 2'(e.fa) && forward_b === 2'(e.fb) && stall === e.st && ex_bubble === e.eb)
          passes++;
        else
          $display("FAIL cyc%0d ctrl: got fa=%b fb=%b stall=%b bubble=%b, want fa=%b fb=%b stall=%b bubble=%b",
                   e.tag, forward_a, forward_b, stall, ex_bubble, 2'(e.fa), 2'(e.fb), e.st, e.eb);
`ifdef FWD_HAZARD_STATS_EN
        checks++;
        if (stat_stall_cycles === 32'(e.s_stall) && stat_fwd_exmem === 32'(e.s_ex) &&
            stat_fwd_memwb === 32'(e.s_wb))
          passes++;
        else
          $display("FAIL cyc%0d stats: got %0d/%0d/%0d, want %0d/%0d/%0d", e.tag, stat_stall_cycles,
                   stat_fwd_exmem, stat_fwd_memwb, e.s_stall, e.s_ex, e.s_wb);
`endif
      end
    end
  end

  initial begin
    exp_t   e;
    instr_t cur;
    model_clear();
    @(posedge clk); #1;
    issue(bubble(), 0);            // outputs in reset
    issue(bubble(), 1);            // flush during reset must not bubble
    reset = 1'b0;

    // add x5,x1,x2 ; sub x6,x5,x3
    send(alu(5, 1, 2)); send(alu(6, 5, 3)); send(nop()); send(nop()); send(nop());
    // add x5 ; nop ; or x7,x3,x5
    send(alu(5, 1, 2)); send(nop()); send(alu(7, 3, 5)); send(nop()); send(nop());
    // addi x5 ; addi x5 ; add x8,x5,x5
    send(addi(5, 1)); send(addi(5, 2)); send(alu(8, 5, 5)); send(nop()); send(nop());
    // ld x9 ; add x10,x9,x1
    send(ld(9, 2)); send(alu(10, 9, 1)); send(nop()); send(nop()); send(nop());
    // addi x0,x0,1 ; add x4,x0,x0
    send(addi(0, 0)); send(alu(4, 0, 0)); send(nop()); send(nop());
    // ld x9 ; add x10,x9,x1 with a simultaneous redirect
    send(ld(9, 2)); issue(alu(10, 9, 1), 1); send(nop()); send(nop());

    // Reset between edges while sub sits in EX with add one stage ahead.
    send(alu(5, 1, 2)); send(alu(6, 5, 3));
    drive_and_expect(nop(), 0, e);
    @(negedge clk); #3;
    e.fa = 0; e.fb = 0; e.st = 0; e.eb = 0; e.s_stall = 0; e.s_ex = 0; e.s_wb = 0; e.tag = cyc;
    exp_q.push_back(e);
    reset = 1'b1;
    #2;
    model_clear();
    @(posedge clk); #1;
    cyc++;
    issue(nop(), 0);
    reset = 1'b0;
    send(alu(2, 5, 5)); send(nop()); send(nop());

    // Random streams; a stalled instruction is re-presented until it enters EX.
    cur = rand_instr();
    repeat (500) begin
      if (!last_stall) cur = rand_instr();
      issue(cur, $urandom_range(0, 9) == 0);
    end
    send(nop()); send(nop());

    repeat (4) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
